load_store_unit: RTL and testbench

Memory-access initiator between the RV32I execute stage and the word-wide data memory. Accepts one load or store request at a time from the pipeline and translates it into the memory's word interface. The memory has a combinational read and a posedge write (byte address, word index = ADDr>>2, Dout = 0 when EN = 0). Sub-word stores are performed as read-modify-write, and sub-word loads are lane-extracted and sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_lane_align.sv | 28 ++
 rtl/load_store_unit.sv | 100 ++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding and request legality check for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? !(f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load lane extract/extend and store lane merge
// ports: funct3/off select width and byte lane; rbuf is the memory word read back,
// wdata the right-aligned store data; rdata is the extended load value, wword the word to write
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rbuf,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wword
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  assign sh = {off, 3'b000};
  assign b  = rbuf[sh +: 8];
  assign h  = rbuf[{off[1], 4'b0000} +: 16];
  always_comb begin
    rdata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'h0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'h0, h} : rbuf;
    wword = funct3 == F3_B ? (rbuf & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh) :
            funct3 == F3_H ? (rbuf & ~(32'hFFFF << sh)) | ({16'h0, wdata[15:0]} << sh) : wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator driving a word-wide memory (RMW for sub-word stores)
// ports: CLK/RST (async active-high); req_* pipeline request handshake; resp_* one-cycle completion;
// EN/RW/ADDr/Din/Dout word memory interface. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of forcing natural alignment.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        EN,
  output logic        RW,
  output logic [31:0] ADDr,
  output logic [31:0] Din,
  input  logic [31:0] Dout
);
  state_t state, next;
  logic we, err, mis, accept, req_err;
  logic [2:0] f3;
  logic [1:0] off;
  logic [31:0] addr, wdata, rbuf, rdata, wword;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign req_err = f3_illegal(req_we, req_funct3) || mis;
  assign accept  = req_valid && state == IDLE;
  // halfword/word lanes are forced to natural alignment; trapping builds never reach here misaligned
  assign off  = f3 == F3_W ? 2'b00 : f3[1:0] == 2'b01 ? {addr[1], 1'b0} : addr[1:0];
  assign ADDr = {addr[31:2], 2'b00};
  lsu_lane_align u_align (
    .funct3(f3),
    .off(off),
    .rbuf(rbuf),
    .wdata(wdata),
    .rdata(rdata),
    .wword(wword)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      we    <= 1'b0;
      err   <= 1'b0;
      f3    <= 3'b000;
      addr  <= 32'h0;
      wdata <= 32'h0;
      rbuf  <= 32'h0;
    end else begin
      state <= next;
      if (accept) begin
        we    <= req_we;
        err   <= req_err;
        f3    <= req_funct3;
        addr  <= req_addr;
        wdata <= req_wdata;
      end
      if (state == READ) rbuf <= Dout;
    end
  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    EN         = 1'b0;
    RW         = 1'b0;
    Din        = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        next = !accept ? IDLE : req_err ? DONE : (req_we && req_funct3 == F3_W) ? WRITE : READ;
      end
      READ: begin
        EN   = 1'b1;
        next = we ? WRITE : DONE;
      end
      WRITE: begin
        EN   = 1'b1;
        RW   = 1'b1;
        Din  = wword;
        next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err;
        resp_rdata = (we || err) ? 32'h0 : rdata;
        next       = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with a transaction-level expected-output model for load_store_unit
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, EN, RW;
  logic [31:0] resp_rdata, ADDr, Din, Dout;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit init_done = 0;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic rdy, vld, err, en, rw, wr, ca, cd;
    logic [31:0] rdata, addr, din;
  } rec_t;
  rec_t q [$];

  load_store_unit dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .EN(EN), .RW(RW), .ADDr(ADDr), .Din(Din), .Dout(Dout)
  );

  always #5 CLK = ~CLK;
  assign Dout = EN ? mem[ADDr[7:2]] : 32'h0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFE_F00D;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h80FF_7F01;
    forever begin
      @(posedge CLK);
      if (EN && RW) begin
        mem[ADDr[7:2]] <= Din;
        wr_cnt++;
      end
      if (EN && !RW) rd_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(logic rdy, vld, err, en, rw, wr, ca, cd, logic [31:0] rdata, addr, din);
    rec_t r;
    r.rdy = rdy; r.vld = vld; r.err = err; r.en = en; r.rw = rw; r.wr = wr; r.ca = ca; r.cd = cd;
    r.rdata = rdata; r.addr = addr; r.din = din;
    return r;
  endfunction

  function automatic bit bad(logic we, logic [2:0] f3, logic [31:0] a);
    bit il = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    bit mis = ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) || (f3 == 3'd2 && a % 4 != 0);
    return il || (TRAP && mis);
  endfunction

  function automatic logic [31:0] ld_exp(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
    int unsigned b0 = a % 4;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * b0)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        b0 = b0 - b0 % 2;
        v = (w >> (8 * b0)) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] st_exp(logic [31:0] w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int unsigned b0 = a % 4;
    logic [31:0] m;
    if (f3 == 3'd2) return wd;
    if (f3 == 3'd1) begin
      b0 = b0 - b0 % 2;
      m = 32'hFFFF << (8 * b0);
    end else m = 32'hFF << (8 * b0);
    return (w & ~m) | ((wd << (8 * b0)) & m);
  endfunction

  function automatic void plan(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic [31:0] aa = a - a % 4;
    logic [31:0] w = ref_mem[aa[7:2]];
    if (bad(we, f3, a)) q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
    else if (!we) begin
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, aa, 32'h0));
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ld_exp(w, f3, a), 32'h0, 32'h0));
    end else begin
      if (f3 != 3'd2) q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, aa, 32'h0));
      q.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 32'h0, aa, st_exp(w, f3, a, wd)));
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
    end
  endfunction

  always @(negedge CLK) begin
    rec_t e;
    if (!init_done) begin
      ref_mem = mem;
      init_done = 1;
    end
    if (RST) begin
      q.delete();
      e = mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
    end else if (q.size() > 0) e = q.pop_front();
    else e = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("req_ready", req_ready, e.rdy);
    chk("resp_valid", resp_valid, e.vld);
    chk("EN", EN, e.en);
    chk("RW", RW, e.rw);
    if (e.vld || RST) begin
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", resp_err, e.err);
    end
    if (e.ca) chk("ADDr", ADDr, e.addr);
    if (e.cd) chk("Din", Din, e.din);
    if (e.wr) ref_mem[e.addr[7:2]] = e.din;
    if (!RST && e.rdy && req_valid) plan(req_we, req_funct3, req_addr, req_wdata);
  end

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    bit ok = 0;
    @(posedge CLK);
    #1;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      ok = req_ready;
    end
    chk("accepted", 32'(ok), 32'h1);
    @(posedge CLK);
    #1 req_valid = 0;
    lat = 0; rd = 32'hx; er = 1'bx; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin
        ok = 1;
        rd = resp_rdata;
        er = resp_err;
      end
    end
    chk("responded", 32'(ok), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, w0, r0, cnt;
    logic [31:0] rd;
    logic er;
    bit ok;
    repeat (3) @(posedge CLK);
    #3 RST = 0;
    xact(0, 3'd0, 32'h9, 0, lat, rd, er);
    chk("LB 0x9 rdata", rd, 32'h0000_007F);
    chk("LB 0x9 latency", lat, 2);
    chk("LB 0x9 err", er, 0);
    xact(0, 3'd0, 32'hA, 0, lat, rd, er);
    chk("LB 0xA rdata", rd, 32'hFFFF_FFFF);
    xact(0, 3'd4, 32'hB, 0, lat, rd, er);
    chk("LBU 0xB rdata", rd, 32'h0000_0080);
    chk("LBU 0xB latency", lat, 2);
    xact(0, 3'd1, 32'hA, 0, lat, rd, er);
    chk("LH 0xA rdata", rd, 32'hFFFF_80FF);
    chk("LH 0xA err", er, 0);
    w0 = wr_cnt;
    xact(1, 3'd0, 32'h6, 32'h0000_00AA, lat, rd, er);
    chk("SB latency", lat, 3);
    chk("SB write count", wr_cnt - w0, 1);
    chk("SB mem word 0x4", mem[1], 32'h11AA_3344);
    xact(0, 3'd2, 32'h4, 0, lat, rd, er);
    chk("LW 0x4 rdata", rd, 32'h11AA_3344);
    r0 = rd_cnt;
    xact(1, 3'd2, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
    chk("SW latency", lat, 2);
    chk("SW no read", rd_cnt - r0, 0);
    chk("SW mem word 0x10", mem[4], 32'hDEAD_BEEF);
    chk("SW rdata", rd, 0);
    xact(1, 3'd1, 32'h12, 32'h1234_BEEF, lat, rd, er);
    chk("SH mem word 0x10", mem[4], 32'hBEEF_BEEF);
    w0 = wr_cnt; r0 = rd_cnt;
    xact(0, 3'd3, 32'h0, 0, lat, rd, er);
    chk("funct3 011 err", er, 1);
    chk("funct3 011 latency", lat, 1);
    chk("funct3 011 no access", (wr_cnt - w0) + (rd_cnt - r0), 0);
    xact(1, 3'd4, 32'h0, 32'h55, lat, rd, er);
    chk("SBU err", er, 1);
    chk("SBU mem untouched", mem[0], 32'hCAFE_F00D);
    xact(0, 3'd2, 32'h2, 0, lat, rd, er);
    chk("LW 0x2 err", er, TRAP);
    chk("LW 0x2 rdata", rd, TRAP ? 32'h0 : 32'hCAFE_F00D);
    xact(0, 3'd1, 32'hB, 0, lat, rd, er);
    chk("LH 0xB err", er, TRAP);
    // SH to 0x8 interrupted by reset during its READ cycle
    w0 = wr_cnt; ok = 0;
    @(posedge CLK);
    #1;
    req_valid = 1; req_we = 1; req_funct3 = 3'd1; req_addr = 32'h8; req_wdata = 32'h5555;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      ok = req_ready;
    end
    @(posedge CLK);
    #1 req_valid = 0;
    #2 RST = 1;
    @(posedge CLK);
    #3 RST = 0;
    chk("reset no write", wr_cnt - w0, 0);
    chk("reset mem word 0x8", mem[2], 32'h80FF_7F01);
    xact(0, 3'd5, 32'h8, 0, lat, rd, er);
    chk("LHU after reset", rd, 32'h0000_7F01);
    chk("LHU after reset latency", lat, 2);
    // back-to-back loads with req_valid held high
    ok = 0;
    @(posedge CLK);
    #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'd4; req_addr = 32'h8;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      ok = req_ready;
    end
    @(posedge CLK);
    #1;
    req_funct3 = 3'd0; req_addr = 32'hB;
    cnt = 0; ok = 0; rd = 32'hx;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      cnt++;
      if (resp_valid) rd = resp_rdata;
      ok = req_ready;
    end
    chk("b2b accept gap", cnt, 3);
    chk("b2b first rdata", rd, 32'h0000_0001);
    @(posedge CLK);
    #1 req_valid = 0;
    ok = 0; lat = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      lat++;
      if (resp_valid) begin
        ok = 1;
        rd = resp_rdata;
      end
    end
    chk("b2b second latency", lat, 2);
    chk("b2b second rdata", rd, 32'hFFFF_FF80);
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
